union_word_packer: RTL and testbench
====================================

Name: union_word_packer

Overview:
- Upstream feeder for the union-select stage.
- Consumes a byte stream with a per-transfer mode tag.
- In word mode, assembles 4 bytes little-endian into a 32-bit int. In byte mode, forwards single bytes.
- Drives select/val_int/val_byte plus a valid/ready handshake, so the downstream stage sees either a complete int or a lone byte.

Parameters:
- TIMEOUT_CYCLES, 16: FILL idle cycles before a partial word is force-flushed; 0 disables the timeout.
- WORD_BYTES, 4: bytes per int. Fixed at 4; any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  byte offered
- in_ready  output  1  packer accepts byte this cycle
- in_byte  input  8  data byte
- in_mode  input  1  1 = word mode, 0 = byte mode; sampled only on the first byte of a transfer
- in_last  input  1  this byte ends the current word; flush early
- out_valid  output  1  output payload valid
- out_ready  input  1  downstream accepts payload
- out_select  output  1  1 = val_int carries a word, 0 = val_byte carries a byte
- out_val_int  output  32  assembled word; 0 when out_select=0
- out_val_byte  output  8  byte-mode byte; lane 0 of the word when out_select=1
- out_partial  output  1  word flushed with fewer than 4 bytes (by in_last or timeout)
- out_count  output  3  number of valid bytes in payload, 1..4

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0 while rst is asserted; all out_* = 0; lane buffer, byte count and timer cleared. A partial word in flight is discarded and never emitted.
- Accept occurs when in_valid && in_ready. in_ready=1 in IDLE and FILL, 0 in HOLD. No accept and emit in the same cycle.
- IDLE, accept with in_mode=0:
  - out_select=0, out_val_byte=in_byte, out_val_int=0, out_count=1, out_partial=0.
  - Next state HOLD.
- IDLE, accept with in_mode=1:
  - Lane0 (bits 7:0) = in_byte, count=1.
  - in_last=1 → HOLD with out_partial=1; otherwise → FILL.
- FILL:
  - Each accept writes lane[count] (bits 8*count+7 : 8*count) and increments count. in_mode is ignored.
  - count reaching 4 → HOLD, out_partial=0.
  - in_last=1 on an accept with count<4 after the write → HOLD, out_partial=1. Unwritten lanes are zero.
  - in_last on the 4th byte → out_partial=0.
  - Timer clears on every accept and increments on each FILL cycle without one. Reaching TIMEOUT_CYCLES → HOLD, out_partial=1, zero-padded.
  - A timeout in the same cycle as an accept: the accept wins and the timer clears.
- HOLD:
  - out_valid=1; all out_* held stable until out_ready.
  - out_ready=1 → out_valid=0 next cycle, state IDLE, buffer cleared.
  - out_valid never drops without out_ready.
- Word-mode outputs: out_select=1, out_val_int = assembled lanes, out_val_byte = lane0.
- Latency: HOLD is entered the cycle after the final accept. Maximum throughput is one payload per (bytes+1) cycles when out_ready is held high.
- Widths: count is 3 bits, saturating at 4 by construction. Timer width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Shared package union_pkg:
  - packed union word_u with fields int u_int / byte u_byte[4].
  - enum mode_e {MODE_BYTE=0, MODE_WORD=1}.
  - enum state_e {IDLE, FILL, HOLD}.
  - localparam WORD_BYTES=4.
- Sub-module union_idle_timer: clear/enable/expired counter parameterised by TIMEOUT_CYCLES.

Test Plan:
- Word mode, bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 → one payload: select=1, val_int=0x44332211, val_byte=0x11, count=4, partial=0, out_valid for 1 cycle.
- Byte mode, single byte 0xA5 with out_ready=0 for 5 cycles → out_valid held, val_byte=0xA5, val_int=0, in_ready=0 throughout, released on out_ready.
- Word mode, 0xDE,0xAD with in_last on the 2nd byte → val_int=0x0000ADDE, count=2, partial=1.
- TIMEOUT_CYCLES=4, word mode, one byte 0x7F then idle → HOLD exactly 4 idle cycles later, val_int=0x0000007F, partial=1. Repeat with a byte on cycle 4 → no flush, timer restarts.
- rst pulsed mid-FILL after 3 bytes → outputs 0 immediately; next word 0x01..0x04 yields 0x04030201 with no stale lanes.
- Mode change mid-word (in_mode=0 on byte 2) → ignored; word completes with select=1.

Source files
------------

// File: rtl/union_pkg.sv
// Shared types for the union-select byte/word path: the lane union, mode and
// state encodings, and helpers that build the downstream payload.
package union_pkg;

    localparam int WORD_BYTES = 4;

    typedef union packed {
        logic [31:0]     u_int;
        logic [3:0][7:0] u_byte;
    } word_u;

    typedef enum logic {
        MODE_BYTE = 1'b0,
        MODE_WORD = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic        select;
        logic [31:0] val_int;
        logic [7:0]  val_byte;
        logic        partial;
        logic [2:0]  count;
    } payload_t;

    function automatic payload_t word_payload(input word_u w, input logic [2:0] count,
                                              input logic partial);
        payload_t p;
        p.select   = 1'b1;
        p.val_int  = w.u_int;
        p.val_byte = w.u_byte[0];
        p.partial  = partial;
        p.count    = count;
        return p;
    endfunction

    function automatic payload_t byte_payload(input logic [7:0] b);
        payload_t p;
        p.select   = 1'b0;
        p.val_int  = 32'h0000_0000;
        p.val_byte = b;
        p.partial  = 1'b0;
        p.count    = 3'd1;
        return p;
    endfunction

endpackage

// File: rtl/union_idle_timer.sv
// Idle counter for a partially filled word; expired pulses on the idle cycle
// that brings the count up to TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 never expires.
module union_idle_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LIMIT = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] LIMIT_V = TW'(LIMIT);
    localparam logic          ACTIVE  = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

    logic [TW-1:0] count_r;

    // Idle-cycle counter; never runs past the expiry point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && ACTIVE && (count_r != LIMIT_V)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = ACTIVE && enable && !clear && (count_r == LIMIT_V);

endmodule

// File: rtl/union_word_packer.sv
// Packs a tagged byte stream into either a little-endian 32-bit word or a lone
// byte and presents it, registered and stable, on a valid/ready interface.
module union_word_packer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WORD_BYTES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_mode,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_select,
    output logic [31:0] out_val_int,
    output logic [7:0]  out_val_byte,
    output logic        out_partial,
    output logic [2:0]  out_count
);

    import union_pkg::*;

    if (WORD_BYTES != union_pkg::WORD_BYTES) begin : g_bad_word_bytes
        $error("union_word_packer: WORD_BYTES must be 4");
    end

    state_e   state_r, state_nx;
    word_u    buf_r, buf_nx;
    logic [2:0] count_r, count_nx;
    logic     out_valid_r, out_valid_nx;
    payload_t payload_r, payload_nx;

    logic       accept_s;
    logic       expired_s;
    logic       timer_clear_s;
    logic       timer_enable_s;
    logic [2:0] lane_count_s;

    assign in_ready       = (state_r != HOLD) && !rst;
    assign accept_s       = in_valid && in_ready;
    assign timer_clear_s  = accept_s || (state_r != FILL);
    assign timer_enable_s = (state_r == FILL) && !accept_s;
    assign lane_count_s   = count_r + 3'd1;

    union_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_s),
        .enable (timer_enable_s),
        .expired(expired_s)
    );

    // Next-state, lane buffer and payload selection.
    always_comb begin
        state_nx     = state_r;
        buf_nx       = buf_r;
        count_nx     = count_r;
        out_valid_nx = out_valid_r;
        payload_nx   = payload_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (mode_e'(in_mode) == MODE_WORD) begin
                        buf_nx           = '0;
                        buf_nx.u_byte[0] = in_byte;
                        count_nx         = 3'd1;
                        if (in_last) begin
                            state_nx     = HOLD;
                            out_valid_nx = 1'b1;
                            payload_nx   = word_payload(buf_nx, 3'd1, 1'b1);
                        end else begin
                            state_nx = FILL;
                        end
                    end else begin
                        state_nx     = HOLD;
                        out_valid_nx = 1'b1;
                        payload_nx   = byte_payload(in_byte);
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    buf_nx.u_byte[count_r[1:0]] = in_byte;
                    count_nx = lane_count_s;
                    if ((lane_count_s == 3'd4) || in_last) begin
                        state_nx     = HOLD;
                        out_valid_nx = 1'b1;
                        payload_nx   = word_payload(buf_nx, lane_count_s, lane_count_s != 3'd4);
                    end else begin
                        state_nx = FILL;
                    end
                end else if (expired_s) begin
                    // Unwritten lanes are already zero from the IDLE clear.
                    state_nx     = HOLD;
                    out_valid_nx = 1'b1;
                    payload_nx   = word_payload(buf_r, count_r, 1'b1);
                end else begin
                    state_nx = FILL;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx     = IDLE;
                    buf_nx       = '0;
                    count_nx     = 3'd0;
                    out_valid_nx = 1'b0;
                    payload_nx   = '0;
                end else begin
                    state_nx = HOLD;
                end
            end
            default: begin
                state_nx     = IDLE;
                buf_nx       = '0;
                count_nx     = 3'd0;
                out_valid_nx = 1'b0;
                payload_nx   = '0;
            end
        endcase
    end

    // State, buffer and registered output payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            buf_r       <= '0;
            count_r     <= 3'd0;
            out_valid_r <= 1'b0;
            payload_r   <= '0;
        end else begin
            state_r     <= state_nx;
            buf_r       <= buf_nx;
            count_r     <= count_nx;
            out_valid_r <= out_valid_nx;
            payload_r   <= payload_nx;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_select   = payload_r.select;
    assign out_val_int  = payload_r.val_int;
    assign out_val_byte = payload_r.val_byte;
    assign out_partial  = payload_r.partial;
    assign out_count    = payload_r.count;

endmodule

// File: tb/tb_union_word_packer.sv
// Directed bench for union_word_packer: expected payloads are queued as the
// stimulus is issued and a negedge monitor pops and compares each transfer.
module tb_union_word_packer;

    typedef logic [44:0] pl_t; // {select, val_int, val_byte, count, partial}

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic        out_select;
    logic [31:0] out_val_int;
    logic [7:0]  out_val_byte;
    logic        out_partial;
    logic [2:0]  out_count;

    int  n_checks = 0;
    int  n_errors = 0;
    pl_t exp_q[$];
    pl_t prev_pl;
    logic stalled = 1'b0;

    union_word_packer #(
        .TIMEOUT_CYCLES(4),
        .WORD_BYTES    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_mode     (in_mode),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_select  (out_select),
        .out_val_int (out_val_int),
        .out_val_byte(out_val_byte),
        .out_partial (out_partial),
        .out_count   (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pl_t mk(input logic sel, input logic [31:0] vi, input logic [7:0] vb,
                               input logic [2:0] cnt, input logic part);
        return {sel, vi, vb, cnt, part};
    endfunction

    function automatic pl_t cur_pl();
        return {out_select, out_val_int, out_val_byte, out_count, out_partial};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: inputs change just after posedge, so at negedge the handshake
    // seen here is the one the next posedge will act on.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_stable", {out_valid, cur_pl()}, {1'b1, prev_pl});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_payload: got %0h expected none", cur_pl());
                end else begin
                    check("payload", cur_pl(), exp_q.pop_front());
                end
            end
            if (out_valid && !out_ready) begin
                stalled = 1'b1;
                prev_pl = cur_pl();
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic slot();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte; returns at the slot after the accepting edge.
    task automatic send(input logic [7:0] b, input logic mode, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_mode  = mode;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            slot();
            guard++;
        end
        check("send_ready", in_ready, 1'b1);
        slot();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'h00;
        in_mode = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        slot();
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_payload", cur_pl(), '0);
        rst = 1'b0;
        slot();

        // Full word back-to-back
        exp_q.push_back(mk(1'b1, 32'h44332211, 8'h11, 3'd4, 1'b0));
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        idle();
        check("word_valid_hi", out_valid, 1'b1);
        slot();
        check("word_valid_lo", out_valid, 1'b0);

        // Byte mode with a stalled consumer; a byte offered during HOLD must be ignored
        out_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 32'h0, 8'hA5, 3'd1, 1'b0));
        send(8'hA5, 1'b0, 1'b0);
        in_byte = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            check("byte_hold_valid", out_valid, 1'b1);
            check("byte_hold_in_ready", in_ready, 1'b0);
            slot();
        end
        idle();
        out_ready = 1'b1;
        slot();
        check("byte_released", out_valid, 1'b0);

        // Early flush with in_last on byte 2
        exp_q.push_back(mk(1'b1, 32'h0000ADDE, 8'hDE, 3'd2, 1'b1));
        send(8'hDE, 1'b1, 1'b0);
        send(8'hAD, 1'b1, 1'b1);
        idle();
        slot();

        // Timeout flush after exactly 4 idle FILL cycles
        exp_q.push_back(mk(1'b1, 32'h0000007F, 8'h7F, 3'd1, 1'b1));
        send(8'h7F, 1'b1, 1'b0);
        idle();
        for (int k = 1; k <= 4; k++) begin
            check("timeout_not_yet", out_valid, 1'b0);
            slot();
        end
        check("timeout_flush", out_valid, 1'b1);
        slot();

        // Byte on the 4th idle cycle wins over the timeout and restarts the timer
        send(8'h7F, 1'b1, 1'b0);
        idle();
        for (int k = 1; k <= 3; k++) begin
            check("restart_pre", out_valid, 1'b0);
            slot();
        end
        exp_q.push_back(mk(1'b1, 32'h0000807F, 8'h7F, 3'd2, 1'b1));
        send(8'h80, 1'b1, 1'b0);
        idle();
        for (int k = 1; k <= 4; k++) begin
            check("restart_not_yet", out_valid, 1'b0);
            slot();
        end
        check("restart_flush", out_valid, 1'b1);
        slot();

        // Reset mid-FILL discards the partial word
        send(8'hAA, 1'b1, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        check("rst_fill_in_ready", in_ready, 1'b0);
        check("rst_fill_out_valid", out_valid, 1'b0);
        slot();
        rst = 1'b0;
        slot();
        exp_q.push_back(mk(1'b1, 32'h00000201, 8'h01, 3'd2, 1'b1));
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b1);
        idle();
        slot();
        exp_q.push_back(mk(1'b1, 32'h04030201, 8'h01, 3'd4, 1'b0));
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        send(8'h04, 1'b1, 1'b1);
        idle();
        slot();

        // Reset during HOLD clears outputs at once and the payload never appears
        out_ready = 1'b0;
        send(8'h55, 1'b1, 1'b1);
        idle();
        check("hold_before_rst", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_hold_out_valid", out_valid, 1'b0);
        check("rst_hold_payload", cur_pl(), '0);
        slot();
        rst = 1'b0;
        out_ready = 1'b1;
        slot();
        slot();
        check("rst_hold_no_emit", out_valid, 1'b0);

        // in_mode after the first byte is ignored
        exp_q.push_back(mk(1'b1, 32'h40302010, 8'h10, 3'd4, 1'b0));
        send(8'h10, 1'b1, 1'b0);
        send(8'h20, 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b0);
        send(8'h40, 1'b0, 1'b0);
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            slot();
        end
        slot();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
